// File: rtl/axi_slave_reg_connector_pkg.sv
// Shared AXI4 channel types for the slave-side register connector.
// Holds the fixed bus widths, the five channel payload structs, the
// request/response bundles exchanged with the IO-PMP, and the default
// spill-register selection per channel.
package axi_slave_reg_connector_pkg;

    localparam int unsigned AXI_DATA_WIDTH   = 32;
    localparam int unsigned AXI_ADDR_WIDTH   = 32;
    localparam int unsigned AXI_STRB_WIDTH   = AXI_DATA_WIDTH / 8;
    localparam int unsigned AXI_ID_WIDTH     = 8;
    localparam int unsigned AXI_AWUSER_WIDTH = 1;
    localparam int unsigned AXI_WUSER_WIDTH  = 1;
    localparam int unsigned AXI_BUSER_WIDTH  = 1;
    localparam int unsigned AXI_ARUSER_WIDTH = 1;
    localparam int unsigned AXI_RUSER_WIDTH  = 1;

    // Default spill-register selection (1 = registered, 0 = wires)
    localparam bit PIPE_AW_DEFAULT = 1'b1;
    localparam bit PIPE_W_DEFAULT  = 1'b1;
    localparam bit PIPE_B_DEFAULT  = 1'b1;
    localparam bit PIPE_AR_DEFAULT = 1'b1;
    localparam bit PIPE_R_DEFAULT  = 1'b1;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]     id;
        logic [AXI_ADDR_WIDTH-1:0]   addr;
        logic [7:0]                  len;
        logic [2:0]                  size;
        logic [1:0]                  burst;
        logic                        lock;
        logic [3:0]                  cache;
        logic [2:0]                  prot;
        logic [3:0]                  qos;
        logic [3:0]                  region;
        logic [5:0]                  atop;
        logic [AXI_AWUSER_WIDTH-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [AXI_DATA_WIDTH-1:0]  data;
        logic [AXI_STRB_WIDTH-1:0]  strb;
        logic                       last;
        logic [AXI_WUSER_WIDTH-1:0] user;
    } w_chan_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]    id;
        logic [1:0]                 resp;
        logic [AXI_BUSER_WIDTH-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]     id;
        logic [AXI_ADDR_WIDTH-1:0]   addr;
        logic [7:0]                  len;
        logic [2:0]                  size;
        logic [1:0]                  burst;
        logic                        lock;
        logic [3:0]                  cache;
        logic [2:0]                  prot;
        logic [3:0]                  qos;
        logic [3:0]                  region;
        logic [AXI_ARUSER_WIDTH-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]    id;
        logic [AXI_DATA_WIDTH-1:0]  data;
        logic [1:0]                 resp;
        logic                       last;
        logic [AXI_RUSER_WIDTH-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     ar_ready;
        logic     w_ready;
        logic     b_valid;
        b_chan_t  b;
        logic     r_valid;
        r_chan_t  r;
    } resp_t;

endpackage

// File: rtl/axi_slave_reg_connector_spill.sv
// Generic two-entry spill register for one valid/ready channel.
// Ports: clk_i/rst_ni (async active-low reset); valid_i/ready_o/data_i
// upstream side; valid_o/ready_i/data_o downstream side.
// Bypass=1 turns the block into plain wires. Otherwise slot A drives the
// output and slot B catches the beat that arrives while A is stalled, so
// the upstream ready depends on registered state only.
module axi_spill_reg #(
    parameter type T      = logic,
    parameter bit  Bypass = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic valid_i,
    output logic ready_o,
    input  T     data_i,
    output logic valid_o,
    input  logic ready_i,
    output T     data_o
);

    if (Bypass) begin : g_bypass
        logic unused_clk_rst_s;
        assign unused_clk_rst_s = clk_i ^ rst_ni;
        assign valid_o = valid_i;
        assign ready_o = ready_i;
        assign data_o  = data_i;
    end else begin : g_spill
        localparam logic [1:0] ST_EMPTY = 2'd0;
        localparam logic [1:0] ST_ONE   = 2'd1;
        localparam logic [1:0] ST_FULL  = 2'd2;

        logic [1:0] state_q, state_d;
        T           a_q, a_d;
        T           b_q, b_d;
        logic       in_hs_s;
        logic       out_hs_s;

        // Decode outputs from state only; an illegal state accepts nothing
        assign ready_o  = (state_q == ST_EMPTY) || (state_q == ST_ONE);
        assign valid_o  = (state_q == ST_ONE) || (state_q == ST_FULL);
        assign data_o   = a_q;
        assign in_hs_s  = valid_i & ready_o;
        assign out_hs_s = valid_o & ready_i;

        // Next-state and slot loading; slots change only on a handshake
        always_comb begin
            state_d = state_q;
            a_d     = a_q;
            b_d     = b_q;
            case (state_q)
                ST_EMPTY: begin
                    if (in_hs_s) begin
                        a_d     = data_i;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_hs_s && out_hs_s) begin
                        a_d     = data_i;
                        state_d = ST_ONE;
                    end else if (in_hs_s) begin
                        b_d     = data_i;
                        state_d = ST_FULL;
                    end else if (out_hs_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (out_hs_s) begin
                        a_d     = b_q;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end

        // State and slot registers
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= ST_EMPTY;
                a_q     <= '0;
                b_q     <= '0;
            end else begin
                state_q <= state_d;
                a_q     <= a_d;
                b_q     <= b_d;
            end
        end
    end

endmodule

// File: rtl/axi_slave_reg_connector.sv
// Slave-side AXI4 connector: takes flat s_axi_* signals from an external
// master and presents them as a req_t toward the IO-PMP, returning the
// resp_t as flat s_axi_* responses. Each channel goes through its own
// axi_spill_reg (registered when *_PIPE=1, wires when 0).
// Ports: clk_i, rst_ni; s_axi_aw*/w*/ar* inputs with *ready outputs;
// s_axi_b*/r* outputs with bready/rready inputs; axi_req_o, axi_resp_i.
module axi_slave_reg_connector
    import axi_slave_reg_connector_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned ID_WIDTH     = 8,
    parameter int unsigned AWUSER_WIDTH = 1,
    parameter int unsigned WUSER_WIDTH  = 1,
    parameter int unsigned BUSER_WIDTH  = 1,
    parameter int unsigned ARUSER_WIDTH = 1,
    parameter int unsigned RUSER_WIDTH  = 1,
    parameter bit          AW_PIPE      = PIPE_AW_DEFAULT,
    parameter bit          W_PIPE       = PIPE_W_DEFAULT,
    parameter bit          B_PIPE       = PIPE_B_DEFAULT,
    parameter bit          AR_PIPE      = PIPE_AR_DEFAULT,
    parameter bit          R_PIPE       = PIPE_R_DEFAULT
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awlock,
    input  logic [3:0]              s_axi_awcache,
    input  logic [2:0]              s_axi_awprot,
    input  logic [3:0]              s_axi_awqos,
    input  logic [3:0]              s_axi_awregion,
    input  logic [AWUSER_WIDTH-1:0] s_axi_awuser,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [STRB_WIDTH-1:0]   s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic [WUSER_WIDTH-1:0]  s_axi_wuser,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic [BUSER_WIDTH-1:0]  s_axi_buser,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arlock,
    input  logic [3:0]              s_axi_arcache,
    input  logic [2:0]              s_axi_arprot,
    input  logic [3:0]              s_axi_arqos,
    input  logic [3:0]              s_axi_arregion,
    input  logic [ARUSER_WIDTH-1:0] s_axi_aruser,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic [RUSER_WIDTH-1:0]  s_axi_ruser,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output req_t                    axi_req_o,
    input  resp_t                   axi_resp_i
);

    aw_chan_t aw_in_s, aw_out_s;
    w_chan_t  w_in_s,  w_out_s;
    ar_chan_t ar_in_s, ar_out_s;
    b_chan_t  b_out_s;
    r_chan_t  r_out_s;
    logic     aw_valid_s, w_valid_s, ar_valid_s;
    logic     b_ready_s, r_ready_s;

    // atop is not exposed by the master side and is always cleared
    assign aw_in_s = '{id: s_axi_awid, addr: s_axi_awaddr, len: s_axi_awlen,
                       size: s_axi_awsize, burst: s_axi_awburst, lock: s_axi_awlock,
                       cache: s_axi_awcache, prot: s_axi_awprot, qos: s_axi_awqos,
                       region: s_axi_awregion, atop: 6'd0, user: s_axi_awuser};
    assign w_in_s  = '{data: s_axi_wdata, strb: s_axi_wstrb, last: s_axi_wlast,
                       user: s_axi_wuser};
    assign ar_in_s = '{id: s_axi_arid, addr: s_axi_araddr, len: s_axi_arlen,
                       size: s_axi_arsize, burst: s_axi_arburst, lock: s_axi_arlock,
                       cache: s_axi_arcache, prot: s_axi_arprot, qos: s_axi_arqos,
                       region: s_axi_arregion, user: s_axi_aruser};

    axi_spill_reg #(.T(aw_chan_t), .Bypass(!AW_PIPE)) u_aw (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .valid_i(s_axi_awvalid), .ready_o(s_axi_awready), .data_i(aw_in_s),
        .valid_o(aw_valid_s), .ready_i(axi_resp_i.aw_ready), .data_o(aw_out_s)
    );

    axi_spill_reg #(.T(w_chan_t), .Bypass(!W_PIPE)) u_w (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .valid_i(s_axi_wvalid), .ready_o(s_axi_wready), .data_i(w_in_s),
        .valid_o(w_valid_s), .ready_i(axi_resp_i.w_ready), .data_o(w_out_s)
    );

    axi_spill_reg #(.T(ar_chan_t), .Bypass(!AR_PIPE)) u_ar (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .valid_i(s_axi_arvalid), .ready_o(s_axi_arready), .data_i(ar_in_s),
        .valid_o(ar_valid_s), .ready_i(axi_resp_i.ar_ready), .data_o(ar_out_s)
    );

    axi_spill_reg #(.T(b_chan_t), .Bypass(!B_PIPE)) u_b (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .valid_i(axi_resp_i.b_valid), .ready_o(b_ready_s), .data_i(axi_resp_i.b),
        .valid_o(s_axi_bvalid), .ready_i(s_axi_bready), .data_o(b_out_s)
    );

    axi_spill_reg #(.T(r_chan_t), .Bypass(!R_PIPE)) u_r (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .valid_i(axi_resp_i.r_valid), .ready_o(r_ready_s), .data_i(axi_resp_i.r),
        .valid_o(s_axi_rvalid), .ready_i(s_axi_rready), .data_o(r_out_s)
    );

    assign s_axi_bid   = b_out_s.id;
    assign s_axi_bresp = b_out_s.resp;
    assign s_axi_buser = b_out_s.user;
    assign s_axi_rid   = r_out_s.id;
    assign s_axi_rdata = r_out_s.data;
    assign s_axi_rresp = r_out_s.resp;
    assign s_axi_rlast = r_out_s.last;
    assign s_axi_ruser = r_out_s.user;

    // Assemble the request bundle toward the IO-PMP
    always_comb begin
        axi_req_o          = '0;
        axi_req_o.aw       = aw_out_s;
        axi_req_o.aw_valid = aw_valid_s;
        axi_req_o.w        = w_out_s;
        axi_req_o.w_valid  = w_valid_s;
        axi_req_o.b_ready  = b_ready_s;
        axi_req_o.ar       = ar_out_s;
        axi_req_o.ar_valid = ar_valid_s;
        axi_req_o.r_ready  = r_ready_s;
    end

endmodule
